// File: rtl/gate_tester_pkg.sv
// Shared types and golden model for the 2-input gate tester.
package gate_tester_pkg;

  localparam int unsigned NUM_VEC = 4;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } gate_op_e;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_e;

  // Expected gate output; any unknown op code behaves as a constant-0 gate.
  function automatic logic golden(input logic [2:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_tester_ref.sv
// Combinational golden model wrapper: op, a, b -> expected output.
module gate_ref
  import gate_tester_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       exp
);

  // Evaluate the selected gate for the current vector
  always_comb begin
    exp = golden(op, a, b);
  end

endmodule

// File: rtl/gate_tester.sv
// Stimulus/check engine for a 2-input gate DUT: sweeps {inB,inA} = 00,01,10,11
// (inA first), samples dut_out after settling and counts mismatches.
// Optional build macro: GATE_TESTER_LOOP_EN (continuous sweeping, sticky results).
module gate_tester
  import gate_tester_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned OP            = 0,
  parameter int unsigned ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_out,
  output logic             inA,
  output logic             inB,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       fail_vec
);

  localparam int unsigned      CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       OP_SEL   = (OP > 5) ? 3'd7 : 3'(OP);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [1:0]       VEC_LAST = 2'(NUM_VEC - 1);

  state_e           state;
  logic [1:0]       vec;
  logic [CNT_W-1:0] settle;
  logic             fail_seen;
  logic             exp;

  gate_ref u_ref (
    .op  (OP_SEL),
    .a   (vec[0]),
    .b   (vec[1]),
    .exp (exp)
  );

  // Sweep FSM, vector/settle counters and result registers.
  // All status outputs are registered from the current state, so they trail
  // the state by one clock; this is what puts done at 4*(SETTLE_CYCLES+1)+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      settle    <= '0;
      fail_seen <= 1'b0;
      inA       <= 1'b0;
      inB       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_vec  <= '0;
    end else begin
      inA  <= vec[0];
      inB  <= vec[1];
      busy <= (state == DRIVE) || (state == SAMPLE);
      done <= (state == DONE);
      pass <= (state == DONE) && (err_cnt == '0);

      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec       <= '0;
            settle    <= '0;
            fail_seen <= 1'b0;
            err_cnt   <= '0;
            fail_vec  <= '0;
            state     <= DRIVE;
          end
`ifdef GATE_TESTER_LOOP_EN
          else if (state == DONE) begin
            vec    <= '0;
            settle <= '0;
            state  <= DRIVE;
          end
`endif
        end
        DRIVE: begin
          if (settle == CNT_LAST) begin
            settle <= '0;
            state  <= SAMPLE;
          end else begin
            settle <= settle + 1'b1;
          end
        end
        SAMPLE: begin
          if (dut_out != exp) begin
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
            if (!fail_seen) begin
              fail_seen <= 1'b1;
              fail_vec  <= vec;
            end
          end
          if (vec == VEC_LAST) begin
            state <= DONE;
          end else begin
            vec   <= vec + 2'd1;
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: two instances (AND/settle 2/3-bit count and
// XOR/settle 1/2-bit count) driving truth-table DUT models.
`timescale 1ns/1ps
module tb_gate_tester;

  localparam int S0 = 2, OP0 = 0, EW0 = 3;
  localparam int S1 = 1, OP1 = 2, EW1 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [3:0] tt0 = 4'b0000, tt1 = 4'b0000;
  logic dout0, dout1;
  logic inA0, inB0, busy0, done0, pass0;
  logic inA1, inB1, busy1, done1, pass1;
  logic [EW0-1:0] err0;
  logic [EW1-1:0] err1;
  logic [1:0] fv0, fv1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Gate under test modelled as a truth table indexed by {inB,inA}
  assign dout0 = tt0[{inB0, inA0}];
  assign dout1 = tt1[{inB1, inA1}];

  gate_tester #(.SETTLE_CYCLES(S0), .OP(OP0), .ERR_W(EW0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .dut_out(dout0),
    .inA(inA0), .inB(inB0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_vec(fv0)
  );

  gate_tester #(.SETTLE_CYCLES(S1), .OP(OP1), .ERR_W(EW1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_out(dout1),
    .inA(inA1), .inB(inB1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fv1)
  );

  // Truth table of each gate, bit index = {b,a}
  function automatic logic [3:0] gold_tt(input int op);
    case (op)
      0: return 4'b1000;
      1: return 4'b1110;
      2: return 4'b0110;
      3: return 4'b0111;
      4: return 4'b0001;
      5: return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int exp_err(input logic [3:0] tt, input int op, input int ew);
    logic [3:0] d;
    int n;
    int mx;
    d  = tt ^ gold_tt(op);
    n  = 0;
    mx = (1 << ew) - 1;
    for (int i = 0; i < 4; i++) if (d[i]) n++;
    return (n > mx) ? mx : n;
  endfunction

  function automatic logic [1:0] exp_fv(input logic [3:0] tt, input int op);
    logic [3:0] d;
    logic [1:0] r;
    logic found;
    d = tt ^ gold_tt(op);
    r = 2'b00;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (d[i] && !found) begin
        r = 2'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic get(input int w, output logic [1:0] v, output logic b, output logic d,
                     output logic p, output logic [3:0] e, output logic [1:0] f);
    if (w == 0) begin
      v = {inB0, inA0}; b = busy0; d = done0; p = pass0; e = 4'(err0); f = fv0;
    end else begin
      v = {inB1, inA1}; b = busy1; d = done1; p = pass1; e = 4'(err1); f = fv1;
    end
  endtask

  // Pulse start on instance w with DUT truth table tt and check the whole sweep
  task automatic run_sweep(input int w, input logic [3:0] tt, input string name);
    int s, op, ew, lat, trace_bad, busy_bad, ee;
    logic [1:0] v, f, efv;
    logic b, d, p;
    logic [3:0] e;
    s  = (w == 0) ? S0 : S1;
    op = (w == 0) ? OP0 : OP1;
    ew = (w == 0) ? EW0 : EW1;
    ee = exp_err(tt, op, ew);
    efv = exp_fv(tt, op);
    trace_bad = 0;
    busy_bad = 0;
    lat = -1;
    @(negedge clk);
    if (w == 0) begin tt0 = tt; start0 = 1'b1; end
    else begin tt1 = tt; start1 = 1'b1; end
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      get(w, v, b, d, p, e, f);
      if (d) begin
        lat = n;
        break;
      end
      if (n <= 4 * (s + 1)) begin
        if (v !== 2'((n - 1) / (s + 1))) trace_bad++;
      end
      if (b !== 1'b1) busy_bad++;
    end
    checks++;
    if (lat != 4 * (s + 1) + 1) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, 4 * (s + 1) + 1);
    end
    checks++;
    if (trace_bad != 0) begin
      errors++;
      $display("FAIL %s_vector_order: %0d bad cycles want 0", name, trace_bad);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s_busy: low in %0d sweep cycles want 0", name, busy_bad);
    end
    checks++;
    if (e !== 4'(ee)) begin
      errors++;
      $display("FAIL %s_err_cnt: got %0d want %0d", name, e, ee);
    end
    checks++;
    if (f !== efv) begin
      errors++;
      $display("FAIL %s_fail_vec: got %b want %b", name, f, efv);
    end
    checks++;
    if (p !== (ee == 0)) begin
      errors++;
      $display("FAIL %s_pass: got %b want %b", name, p, (ee == 0));
    end
    checks++;
    if ({b, v} !== 3'b011) begin
      errors++;
      $display("FAIL %s_done_hold: busy,inB,inA got %b want 011", name, {b, v});
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({inA0, inB0, busy0, done0, pass0, err0, fv0} !== '0) begin
      errors++;
      $display("FAIL reset0: got %b want 0", {inA0, inB0, busy0, done0, pass0, err0, fv0});
    end
    checks++;
    if ({inA1, inB1, busy1, done1, pass1, err1, fv1} !== '0) begin
      errors++;
      $display("FAIL reset1: got %b want 0", {inA1, inB1, busy1, done1, pass1, err1, fv1});
    end
  endtask

  task automatic test_directed();
    run_sweep(0, 4'b1000, "and_ok");
    run_sweep(0, 4'b1111, "and_stuck1");
    run_sweep(1, 4'b1110, "or_vs_xor");
    run_sweep(1, 4'b1001, "xnor_vs_xor_sat");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_sweep(i % 2, 4'($urandom_range(0, 15)), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    tt0 = 4'b1111;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (err0 !== 3'd2) begin
      errors++;
      $display("FAIL midreset_err_before: got %0d want 2", err0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({inA0, inB0, busy0, done0, pass0, err0, fv0} !== '0) begin
      errors++;
      $display("FAIL midreset_clear: got %b want 0", {inA0, inB0, busy0, done0, pass0, err0, fv0});
    end
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, 4'b1000, "after_reset");
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    lat1 = -1;
    lat2 = -1;
    @(negedge clk);
    tt0 = 4'b1000;
    start0 = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done0) begin lat1 = n; break; end
    end
    start0 = 1'b0;
    checks++;
    if (lat1 != 13) begin
      errors++;
      $display("FAIL held_start_first_done: got %0d want 13", lat1);
    end
    for (int n = lat1 + 1; n <= lat1 + 40; n++) begin
      @(posedge clk); #1;
      if (done0 && n > lat1 + 1) begin lat2 = n; break; end
    end
    checks++;
    if (lat2 != 26) begin
      errors++;
      $display("FAIL held_start_second_done: got %0d want 26", lat2);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({done0, busy0, pass0, err0} !== {3'b101, 3'd0}) begin
      errors++;
      $display("FAIL held_start_done_hold: done,busy,pass,err got %b want 101000", {done0, busy0, pass0, err0});
    end
  endtask

  task automatic test_loop();
    int n, ek;
    @(negedge clk);
    tt0 = 4'b0000;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!done0 && n < 40);
      ek = (k > 7) ? 7 : k;
      checks++;
      if (n != 13) begin
        errors++;
        $display("FAIL loop%0d_period: got %0d want 13", k, n);
      end
      checks++;
      if ({err0, fv0, pass0} !== {3'(ek), 2'b11, 1'b0}) begin
        errors++;
        $display("FAIL loop%0d_result: err,fv,pass got %0d,%b,%b want %0d,11,0", k, err0, fv0, pass0, ek);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
`ifdef GATE_TESTER_LOOP_EN
    test_loop();
`else
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
